// File: rtl/invert_8b_if.sv
// Handshake/data bundle for the byte bit-order reverser.
// The master drives the byte and its qualifiers; the slave returns both mirrors and parity.
interface invert_8b_if;
  logic [7:0] din;
  logic       in_vld;
  logic       bypass;
  logic [7:0] dout;
  logic [7:0] dout_q;
  logic       out_vld;
  logic       par_q;

  modport master (
    output din,
    output in_vld,
    output bypass,
    input  dout,
    input  dout_q,
    input  out_vld,
    input  par_q
  );

  modport slave (
    input  din,
    input  in_vld,
    input  bypass,
    output dout,
    output dout_q,
    output out_vld,
    output par_q
  );
endinterface

// File: rtl/invert_8b.sv
// Byte bit-order reverser: MSB-first host bytes become LSB-first line bytes.
// Zero-latency combinational mirror plus a one-cycle registered mirror with even parity.
module invert_8b #(
  parameter logic [7:0] RST_VAL = 8'h00,
  parameter bit         PASS_EN = 1'b1
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  invert_8b_if.slave  bus
);

  function automatic logic [7:0] mirror(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic parity(input logic [7:0] b);
    return ^b;
  endfunction

  logic [7:0] dout_p1;
  logic       par_p1;
  logic       vld_p1;
  logic       pass_sel;

  assign bus.dout = mirror(bus.din);
  assign pass_sel = bus.bypass & PASS_EN;

  // Stage p0 -> p1: capture qualified byte; parity is taken pre-mirror since reversal preserves it
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      dout_p1 <= RST_VAL;
      par_p1  <= parity(RST_VAL);
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= bus.in_vld;
      if (bus.in_vld) begin
        dout_p1 <= pass_sel ? bus.din : mirror(bus.din);
        par_p1  <= parity(bus.din);
      end
    end
  end

  assign bus.dout_q  = dout_p1;
  assign bus.par_q   = par_p1;
  assign bus.out_vld = vld_p1;

endmodule

// File: tb/tb_invert_8b.sv
// Directed bench for invert_8b: one reversing instance and one with bypass disabled.
module tb_invert_8b;
  logic clk_sys = 1'b0;
  logic clk_en  = 1'b0;
  logic rst_n   = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  invert_8b_if bus_a ();
  invert_8b_if bus_b ();

  invert_8b #(.RST_VAL(8'h00), .PASS_EN(1'b1)) u_dut_a (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus_a)
  );

  invert_8b #(.RST_VAL(8'h00), .PASS_EN(1'b0)) u_dut_b (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus_b)
  );

  always begin
    #5;
    if (clk_en) clk_sys = ~clk_sys;
  end

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = b[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic b);
    bus_a.din = d; bus_a.in_vld = v; bus_a.bypass = b;
    bus_b.din = d; bus_b.in_vld = v; bus_b.bypass = b;
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  initial begin
    logic [7:0] r;
    drive(8'h00, 1'b0, 1'b0);

    // Combinational mirror with no clock running
    drive(8'hb0, 1'b0, 1'b0); #1 chk("comb_b0", bus_a.dout, 8'h0d);
    drive(8'h00, 1'b0, 1'b0); #1 chk("comb_00", bus_a.dout, 8'h00);
    drive(8'h30, 1'b0, 1'b0); #1 chk("comb_30", bus_a.dout, 8'h0c);
    drive(8'h01, 1'b0, 1'b0); #1 chk("comb_01", bus_a.dout, 8'h80);
    chk("comb_01_b", bus_b.dout, 8'h80);

    // Held in reset with clock toggling and valid input present
    drive(8'hff, 1'b1, 1'b0);
    clk_en = 1'b1;
    repeat (3) tick();
    chk("rst_dout_q", bus_a.dout_q, 8'h00);
    chk("rst_out_vld", bus_a.out_vld, 1'b0);
    chk("rst_par_q", bus_a.par_q, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("rel_dout_q", bus_a.dout_q, 8'hff);
    chk("rel_par_q", bus_a.par_q, 1'b0);
    chk("rel_out_vld", bus_a.out_vld, 1'b1);

    // Back-to-back stream
    drive(8'hb0, 1'b1, 1'b0); tick();
    chk("s0_dout_q", bus_a.dout_q, 8'h0d); chk("s0_vld", bus_a.out_vld, 1'b1); chk("s0_par", bus_a.par_q, 1'b1);
    drive(8'h00, 1'b1, 1'b0); tick();
    chk("s1_dout_q", bus_a.dout_q, 8'h00); chk("s1_vld", bus_a.out_vld, 1'b1); chk("s1_par", bus_a.par_q, 1'b0);
    drive(8'h30, 1'b1, 1'b0); tick();
    chk("s2_dout_q", bus_a.dout_q, 8'h0c); chk("s2_vld", bus_a.out_vld, 1'b1); chk("s2_par", bus_a.par_q, 1'b0);
    drive(8'h01, 1'b1, 1'b0); tick();
    chk("s3_dout_q", bus_a.dout_q, 8'h80); chk("s3_vld", bus_a.out_vld, 1'b1); chk("s3_par", bus_a.par_q, 1'b1);
    drive(8'h01, 1'b0, 1'b0); tick();
    chk("s_end_vld", bus_a.out_vld, 1'b0); chk("s_end_hold", bus_a.dout_q, 8'h80);

    // Bypass honoured on A, ignored on B
    drive(8'h01, 1'b1, 1'b1); tick();
    chk("byp_a_dout_q", bus_a.dout_q, 8'h01); chk("byp_a_par", bus_a.par_q, 1'b1);
    chk("byp_b_dout_q", bus_b.dout_q, 8'h80); chk("byp_b_par", bus_b.par_q, 1'b1);
    drive(8'h01, 1'b0, 1'b0); tick();
    chk("byp_a_hold", bus_a.dout_q, 8'h01);

    // Single capture then hold while din wanders
    drive(8'h12, 1'b1, 1'b0); tick();
    chk("hold_cap", bus_a.dout_q, 8'h48); chk("hold_vld1", bus_a.out_vld, 1'b1); chk("hold_par", bus_a.par_q, 1'b0);
    drive(8'hff, 1'b0, 1'b1); tick();
    chk("hold_q1", bus_a.dout_q, 8'h48); chk("hold_vld2", bus_a.out_vld, 1'b0);
    drive(8'h5a, 1'b0, 1'b0); tick();
    chk("hold_q2", bus_a.dout_q, 8'h48); chk("hold_vld3", bus_a.out_vld, 1'b0);

    // Asynchronous reset between edges
    drive(8'hc5, 1'b1, 1'b0);
    @(posedge clk_sys); #1;
    chk("mid_pre_vld", bus_a.out_vld, 1'b1); chk("mid_pre_q", bus_a.dout_q, 8'ha3);
    rst_n = 1'b0; #1;
    chk("mid_vld", bus_a.out_vld, 1'b0); chk("mid_q", bus_a.dout_q, 8'h00); chk("mid_par", bus_a.par_q, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rel_vld", bus_a.out_vld, 1'b0);

    // Exhaustive sweep
    for (int v = 0; v < 256; v++) begin
      drive(v[7:0], 1'b1, 1'b0); #1;
      r = bus_a.dout;
      chk("ex_comb", r, rev8(v[7:0]));
      tick();
      chk("ex_par", bus_a.par_q, ^v[7:0]);
      chk("ex_dout_q", bus_a.dout_q, rev8(v[7:0]));
      drive(r, 1'b0, 1'b0); #1;
      chk("ex_round", bus_a.dout, v[7:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
